iir_decim_buf: RTL and testbench
================================

IIR_DECIM_BUF -- requirements
Module: iir_decim_buf

Interface
REQ-001 The block SHALL have parameter DECIM, default 4, giving the decimation ratio (power of 2, 2..64).
REQ-002 The block SHALL have parameter OUT_W, default 12, giving the output sample width in bits (signed, 4..16).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, giving the output buffer entries (power of 2, >=2).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clk in 1 (rising edge), rst_n in 1 (synchronous, active-low).
REQ-005 Port data_in SHALL be an input, signed [15:0], carrying the IIR filter output sample.
REQ-006 Port in_valid SHALL be an input, 1 bit, marking data_in as a new sample.
REQ-007 Port data_out SHALL be an output, signed [OUT_W-1:0], carrying the FIFO head sample.
REQ-008 Port out_valid SHALL be an output, 1 bit, high when the FIFO is non-empty.
REQ-009 Port out_ready SHALL be an input, 1 bit, signalling that the consumer accepts data_out.
REQ-010 Port level SHALL be an output, [$clog2(FIFO_DEPTH):0], giving the current FIFO occupancy.
REQ-011 Port drop_cnt SHALL be an output, [7:0], counting dropped decimated samples (saturating at 255).

Function
REQ-012 The accumulator SHALL be signed, 16+$clog2(DECIM) bits wide, and never overflow.
REQ-013 Phase counter 0..DECIM-1 SHALL advance only on in_valid; in_valid low SHALL leave all state unchanged.
REQ-014 On in_valid at phase<DECIM-1: acc <= acc+data_in; phase <= phase+1.
REQ-015 On in_valid at phase==DECIM-1: avg = (acc+data_in) >>> $clog2(DECIM) (arithmetic, floor); acc <= 0; phase <= 0; avg reduced to OUT_W bits (REQ-023/024) and pushed.
REQ-016 Latency: with FIFO empty, the sample SHALL appear on data_out with out_valid=1 on the cycle after the DECIM-th accepted input.
REQ-017 Push when level==FIFO_DEPTH with no pop that cycle: sample dropped; drop_cnt+1 (saturates at 255); accumulation restarts normally.
REQ-018 Push and pop in the same cycle while full: both SHALL succeed; level unchanged; drop_cnt unchanged.
REQ-019 Pop occurs iff out_valid && out_ready; out_ready while empty SHALL have no effect.
REQ-020 data_out and out_valid SHALL be stable while out_valid && !out_ready.
REQ-021 When empty, data_out SHALL hold its last value (0 after reset).
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level SHALL be exact 0..FIFO_DEPTH.

Configuration
REQ-023 With IIR_DECIM_SAT_EN defined, avg SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-024 Without IIR_DECIM_SAT_EN, avg SHALL be truncated to its low OUT_W bits (two's-complement wrap).

Reset
REQ-025 With rst_n low at a clk edge: acc=0, phase=0, FIFO empty, level=0, out_valid=0, data_out=0, drop_cnt=0.
REQ-026 A reset mid-block SHALL discard the partial accumulation and all buffered samples; the first DECIM inputs after release form a fresh block.
REQ-027 Inputs SHALL be ignored while rst_n is low.

Structure
REQ-028 Package iir_pkg SHALL hold the sample width constant (16), the drop counter width (8), and the sample typedef shared with the IIR stage.
REQ-029 The FIFO SHALL be one sub-module, iir_sync_fifo (parameterised width/depth, push/pop/full/empty/level).
REQ-030 Elaboration SHALL reject a non-power-of-2 DECIM or FIFO_DEPTH.

Verification
REQ-031 DECIM=4, OUT_W=12, continuous in_valid, inputs 100,200,300,400, out_ready=1 -> data_out=250 one cycle after the 4th input; level returns to 0.
REQ-032 Inputs -7,-7,-7,-6 -> data_out=-7 (floor of -6.75).
REQ-033 Four inputs of 32767 -> 2047 with IIR_DECIM_SAT_EN; -1 (0xFFF) without it.
REQ-034 out_ready=0, nine decimated samples produced -> level=8, drop_cnt=1, first eight values retained in order; then out_ready=1 -> eight pops in order, out_valid falls.
REQ-035 FIFO full with a push and pop in the same cycle -> level stays 8, drop_cnt unchanged, new sample at tail.
REQ-036 Two inputs (500,500), rst_n low for 1 cycle, then 4,8,12,16 -> single output 10; drop_cnt=0.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared sample/counter types for the IIR filter and its decimating output buffer.
// No logic, no latency; purely type and constant definitions.
// No backpressure involvement.
package iir_pkg;
    localparam int SAMPLE_W = 16;
    localparam int DROP_W   = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/iir_sync_fifo.sv
// Generic synchronous FIFO with combinational head read and exact occupancy count.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: push while full is accepted only if a pop happens the same cycle.
module iir_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic            do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers/level define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/iir_decim_buf.sv
// Block-average decimator (DECIM:1) feeding an output FIFO; IIR_DECIM_SAT_EN selects saturation over wrap.
// Latency: averaged sample valid on data_out the cycle after the DECIM-th accepted input (FIFO empty).
// Backpressure: valid/ready on the output; a decimated sample arriving at a full FIFO is dropped and counted.
module iir_decim_buf
    import iir_pkg::*;
#(
    parameter int DECIM      = 4,
    parameter int OUT_W      = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [SAMPLE_W-1:0]    data_in,
    input  logic                          in_valid,
    output logic signed [OUT_W-1:0]       data_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [DROP_W-1:0]             drop_cnt
);
    localparam int LOG2D = $clog2(DECIM);
    localparam int ACC_W = SAMPLE_W + LOG2D;
    localparam logic [LOG2D-1:0] PH_LAST = LOG2D'(DECIM - 1);

    if (DECIM < 2 || DECIM > 64 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
        $error("iir_decim_buf: DECIM must be a power of 2 in 2..64");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("iir_decim_buf: FIFO_DEPTH must be a power of 2 >= 2");
    end

    logic signed [ACC_W-1:0] acc, sum;
    logic [LOG2D-1:0]        phase;
    sample_t                 avg;
    logic signed [OUT_W-1:0] avg_red, head, hold;
    logic                    blk_done, pop, full, empty;
    logic [DROP_W-1:0]       drops;

    // ACC_W holds the sum of DECIM full-scale samples, so no overflow is possible.
    assign sum      = acc + {{LOG2D{data_in[SAMPLE_W-1]}}, data_in};
    assign avg      = sample_t'(sum >>> LOG2D);
    assign blk_done = in_valid && (phase == PH_LAST);
    assign pop      = !empty && out_ready;

`ifdef IIR_DECIM_SAT_EN
    localparam sample_t MAXV = sample_t'((1 << (OUT_W - 1)) - 1);
    localparam sample_t MINV = sample_t'(-(1 << (OUT_W - 1)));

    always_comb begin
        avg_red = OUT_W'(avg);
        if (avg > MAXV)      avg_red = OUT_W'(MAXV);
        else if (avg < MINV) avg_red = OUT_W'(MINV);
    end
`else
    assign avg_red = OUT_W'(avg);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            phase <= '0;
            drops <= '0;
            hold  <= '0;
        end else begin
            if (blk_done) begin
                acc   <= '0;
                phase <= '0;
            end else if (in_valid) begin
                acc   <= sum;
                phase <= phase + LOG2D'(1);
            end
            if (blk_done && full && !pop && drops != '1) drops <= drops + DROP_W'(1);
            if (pop) hold <= head;
        end
    end

    iir_sync_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (blk_done),
        .push_dat (avg_red),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    // Once drained, keep showing the last popped sample rather than stale storage.
    assign data_out  = empty ? hold : head;
    assign out_valid = !empty;
    assign drop_cnt  = drops;
endmodule

// File: tb/tb_iir_decim_buf.sv
// Scoreboard bench for iir_decim_buf with DECIM=4, OUT_W=12, FIFO_DEPTH=8.
module tb_iir_decim_buf;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] data_in = '0;
    logic               in_valid = 1'b0;
    logic signed [11:0] data_out;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [3:0]         level;
    logic [7:0]         drop_cnt;

    int exp_q[$];
    int m_acc, m_phase, m_drop, m_last;
    int total = 0;
    int bad = 0;

    iir_decim_buf #(.DECIM(4), .OUT_W(12), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic int reduce(input int a);
        int r;
`ifdef IIR_DECIM_SAT_EN
        r = (a > 2047) ? 2047 : ((a < -2048) ? -2048 : a);
`else
        r = a & 32'h0fff;
        if (r >= 2048) r = r - 4096;
`endif
        return r;
    endfunction

    // One clock: pop-side compare before the edge, model update after it.
    task automatic tick(input bit v, input int d, input bit rdy);
        int av;
        logic signed [11:0] e;
        in_valid  = v;
        data_in   = 16'(d);
        out_ready = rdy;
        if (rdy && exp_q.size() > 0) begin
            e = 12'(exp_q[0]);
            total++;
            if (out_valid !== 1'b1 || data_out !== e) begin
                bad++;
                $display("FAIL pop_order: got valid=%b data=%0d, want valid=1 data=%0d", out_valid, data_out, e);
            end
            m_last = exp_q.pop_front();
        end
        @(posedge clk);
        #1;
        if (v) begin
            if (m_phase == 3) begin
                av = (m_acc + d) >>> 2;
                if (exp_q.size() < 8) exp_q.push_back(reduce(av));
                else if (m_drop < 255) m_drop++;
                m_acc = 0;
                m_phase = 0;
            end else begin
                m_acc += d;
                m_phase++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        in_valid = 1'b1;
        data_in = 16'sd1234;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        exp_q.delete();
        m_acc = 0; m_phase = 0; m_drop = 0; m_last = 0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        total++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            bad++; $display("FAIL reset_flags: got valid=%b level=%0d, want 0/0", out_valid, level);
        end
        total++;
        if (data_out !== 12'sd0 || drop_cnt !== 8'd0) begin
            bad++; $display("FAIL reset_data: got data=%0d drop=%0d, want 0/0", data_out, drop_cnt);
        end
        release_reset();
    endtask

    task automatic test_average();
        tick(1, 100, 1); tick(1, 200, 1); tick(1, 300, 1); tick(1, 400, 1);
        total++;
        if (out_valid !== 1'b1 || data_out !== 12'sd250) begin
            bad++; $display("FAIL avg_latency: got valid=%b data=%0d, want 1/250", out_valid, data_out);
        end
        tick(0, 0, 1);
        total++;
        if (level !== 4'd0 || out_valid !== 1'b0 || data_out !== 12'sd250) begin
            bad++; $display("FAIL avg_drain: got level=%0d valid=%b data=%0d, want 0/0/250", level, out_valid, data_out);
        end
    endtask

    task automatic test_floor_gaps();
        tick(1, -7, 1); tick(0, 99, 1); tick(1, -7, 1); tick(0, 0, 1); tick(0, 0, 1);
        tick(1, -7, 1); tick(0, 5, 1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL gap_no_output: got valid=%b, want 0", out_valid);
        end
        tick(1, -6, 1);
        total++;
        if (data_out !== -12'sd7) begin
            bad++; $display("FAIL floor: got %0d, want -7", data_out);
        end
        tick(0, 0, 1);
    endtask

    task automatic test_saturation();
        logic signed [11:0] e;
        repeat (4) tick(1, 32767, 1);
`ifdef IIR_DECIM_SAT_EN
        e = 12'sd2047;
`else
        e = -12'sd1;
`endif
        total++;
        if (data_out !== e) begin
            bad++; $display("FAIL sat_pos: got %0d, want %0d", data_out, e);
        end
        tick(0, 0, 1);
        repeat (4) tick(1, -32768, 1);
`ifdef IIR_DECIM_SAT_EN
        e = -12'sd2048;
`else
        e = 12'sd0;
`endif
        total++;
        if (data_out !== e) begin
            bad++; $display("FAIL sat_neg: got %0d, want %0d", data_out, e);
        end
        tick(0, 0, 1);
    endtask

    task automatic test_full_drop();
        do_reset(1);
        release_reset();
        for (int k = 1; k <= 9; k++)
            for (int i = 0; i < 4; i++) tick(1, k * 100 + i * 10, 0);
        total++;
        if (level !== 4'd8 || drop_cnt !== 8'd1) begin
            bad++; $display("FAIL full_drop: got level=%0d drop=%0d, want 8/1", level, drop_cnt);
        end
        tick(0, 0, 0); tick(0, 0, 0);
        total++;
        if (out_valid !== 1'b1 || data_out !== 12'sd115) begin
            bad++; $display("FAIL hold_stable: got valid=%b data=%0d, want 1/115", out_valid, data_out);
        end
        repeat (8) tick(0, 0, 1);
        total++;
        if (out_valid !== 1'b0 || level !== 4'd0 || data_out !== 12'sd815) begin
            bad++; $display("FAIL drain_done: got valid=%b level=%0d data=%0d, want 0/0/815", out_valid, level, data_out);
        end
        tick(0, 0, 1);
    endtask

    task automatic test_back_to_back_full();
        int d0;
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 4; i++) tick(1, 40 * k - 150 + i, 0);
        d0 = m_drop;
        tick(1, 1000, 0); tick(1, 1000, 0); tick(1, 1000, 0);
        tick(1, 1004, 1);
        total++;
        if (level !== 4'd8 || drop_cnt !== 8'(d0)) begin
            bad++; $display("FAIL push_pop_full: got level=%0d drop=%0d, want 8/%0d", level, drop_cnt, d0);
        end
        repeat (9) tick(0, 0, 1);
        total++;
        if (out_valid !== 1'b0 || data_out !== 12'sd1001) begin
            bad++; $display("FAIL tail_sample: got valid=%b data=%0d, want 0/1001", out_valid, data_out);
        end
    endtask

    task automatic test_drop_saturate();
        for (int k = 0; k < 270; k++)
            for (int i = 0; i < 4; i++) tick(1, k, 0);
        total++;
        if (drop_cnt !== 8'd255 || level !== 4'd8) begin
            bad++; $display("FAIL drop_sat: got drop=%0d level=%0d, want 255/8", drop_cnt, level);
        end
        repeat (9) tick(0, 0, 1);
    endtask

    task automatic test_mid_reset();
        tick(1, 500, 1); tick(1, 500, 1);
        do_reset(1);
        release_reset();
        tick(1, 4, 0); tick(1, 8, 0); tick(1, 12, 0); tick(1, 16, 0);
        total++;
        if (out_valid !== 1'b1 || data_out !== 12'sd10 || level !== 4'd1 || drop_cnt !== 8'd0) begin
            bad++; $display("FAIL mid_reset: got valid=%b data=%0d level=%0d drop=%0d, want 1/10/1/0",
                            out_valid, data_out, level, drop_cnt);
        end
        tick(0, 0, 1); tick(0, 0, 1);
        total++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            bad++; $display("FAIL mid_reset_drain: got valid=%b level=%0d, want 0/0", out_valid, level);
        end
    endtask

    initial begin
        test_reset();
        test_average();
        test_floor_gaps();
        test_saturation();
        test_full_drop();
        test_back_to_back_full();
        test_drop_saturate();
        test_mid_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
